// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and alignment helper for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_WRITE = 2'd2,
    DONE      = 2'd3
  } lsu_state_t;

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory bus of the load/store unit
interface load_store_unit_if #(
  parameter int N = 32
);
  logic         req_valid;
  logic         req_write;
  logic [2:0]   req_funct3;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         busy;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_err;
  logic [N-1:0] mem_addr;
  logic         mem_write_enable;
  logic [N-1:0] mem_write_data;
  logic [N-1:0] mem_read_data;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output busy, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_enable, mem_write_data
  );

  // The core plus data memory around it.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  busy, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load byte/half extraction with extension, and store lane merge
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] word_i,
  input  logic [1:0]   offset_i,
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] load_data_o,
  output logic [N-1:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

  // Load result: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    load_data_o = word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{(N-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {{(N-8){1'b0}}, byte_sel};
      F3_H:    load_data_o = {{(N-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {{(N-16){1'b0}}, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  // Store merge: replace only the addressed lane of the word read back.
  always_comb begin
    store_word_o = word_i;
    case (funct3_i)
      F3_B:    store_word_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    store_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N    = 32,
  parameter int SIZE = 64
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  lsu_state_t   state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [1:0]   off_q, off_d;
  logic [2:0]   f3_q, f3_d;
  logic         wr_q, wr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         err_q, err_d;

  logic [N-1:0] req_idx;
  logic         req_err;
  logic [N-1:0] load_data;
  logic [N-1:0] merged_word;

  logic         we_c;
  logic [N-1:0] wd_c;
  logic [N-1:0] mem_addr_c;
  logic         resp_valid_c;
  logic [N-1:0] resp_rdata_c;
  logic         resp_err_c;

  assign req_idx = {2'b00, bus.req_addr[N-1:2]};

  // Reject misaligned, undefined funct3, store with unsigned funct3, or index beyond memory.
  always_comb begin
    req_err = is_misaligned(bus.req_funct3, bus.req_addr[1:0])
           || (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) || (bus.req_funct3 == 3'b111)
           || (bus.req_write && bus.req_funct3[2])
           || (req_idx >= N'(SIZE));
  end

  lsu_lane_align #(.N(N)) u_align (
    .word_i      (bus.mem_read_data),
    .offset_i    (off_q),
    .funct3_i    (f3_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .store_word_o(merged_word)
  );

  // Next state, request latching and memory/response drive.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    f3_d         = f3_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    we_c         = 1'b0;
    wd_c         = '0;
    mem_addr_c   = addr_q;
    resp_valid_c = 1'b0;
    resp_rdata_c = '0;
    resp_err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_addr_c = req_idx;
        if (bus.req_valid) begin
          addr_d  = req_idx;
          off_d   = bus.req_addr[1:0];
          f3_d    = bus.req_funct3;
          wr_d    = bus.req_write;
          wdata_d = bus.req_wdata;
          err_d   = req_err;
          if (req_err) begin
            state_d = DONE;
          end else if (bus.req_write) begin
            if (bus.req_funct3 == F3_W) begin
              we_c    = 1'b1;
              wd_c    = bus.req_wdata;
              state_d = DONE;
            end else begin
              state_d = RMW_WRITE;
            end
          end else begin
            state_d = LOAD_RESP;
          end
        end
      end
      LOAD_RESP: begin
        resp_valid_c = 1'b1;
        resp_rdata_c = load_data;
        state_d      = IDLE;
      end
      RMW_WRITE: begin
        we_c    = wr_q;
        wd_c    = merged_word;
        state_d = DONE;
      end
      DONE: begin
        resp_valid_c = 1'b1;
        resp_err_c   = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request, cleared by reset so a pending RMW is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy             = (state_q != IDLE);
  assign bus.resp_valid       = resp_valid_c;
  assign bus.resp_rdata       = resp_rdata_c;
  assign bus.resp_err         = resp_err_c;
  assign bus.mem_addr         = mem_addr_c;
  assign bus.mem_write_enable = we_c & ~rst;
  assign bus.mem_write_data   = wd_c;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench with a behavioural memory reference
module tb_load_store_unit;
  localparam int N    = 32;
  localparam int SIZE = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.N(N)) bus ();

  load_store_unit #(.N(N), .SIZE(SIZE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous-read data memory with a bench preload port.
  logic [31:0] mem [SIZE];
  logic [31:0] rd_q;
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (bus.mem_write_enable) begin
      if (bus.mem_addr < SIZE) mem[bus.mem_addr[5:0]] <= bus.mem_write_data;
    end else begin
      rd_q <= (bus.mem_addr < SIZE) ? mem[bus.mem_addr[5:0]] : 32'h0;
    end
  end
  assign bus.mem_read_data = rd_q;

  logic [31:0] ref_mem [SIZE];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx[5:0];
    pl_val = val;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag, output logic [31:0] rdata);
    logic [31:0] idx, w, b, h, exp_rd;
    logic        exp_err, we_seen, got, got_err;
    int          sh, exp_lat, lat;
    idx     = addr >> 2;
    sh      = 8 * int'(addr[1:0]);
    exp_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2])
           || ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00)
           || (idx >= SIZE);
    exp_lat = (!exp_err && wr && f3 != 3'd2) ? 2 : 1;
    exp_rd  = 32'h0;
    w       = (idx < SIZE) ? ref_mem[idx[5:0]] : 32'h0;
    b       = (w >> sh) & 32'hFF;
    h       = (w >> sh) & 32'hFFFF;
    if (!exp_err && !wr) begin
      case (f3)
        3'd0: exp_rd = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
        3'd4: exp_rd = b;
        3'd1: exp_rd = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
        3'd5: exp_rd = h;
        default: exp_rd = w;
      endcase
    end
    if (!exp_err && wr) begin
      case (f3)
        3'd0: ref_mem[idx[5:0]] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        3'd1: ref_mem[idx[5:0]] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        default: ref_mem[idx[5:0]] = wd;
      endcase
    end
    for (int k = 0; k < 10 && bus.busy; k++) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
    we_seen = bus.mem_write_enable;
    @(posedge clk);
    lat     = 0;
    got     = 1'b0;
    got_err = 1'b0;
    rdata   = 32'h0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      lat++;
      we_seen = we_seen | bus.mem_write_enable;
      if (bus.resp_valid) begin
        got       = 1'b1;
        rdata     = bus.resp_rdata;
        got_err   = bus.resp_err;
        bus.req_valid = 1'b0;
      end else begin
        // Junk store held while busy must be ignored.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = $urandom_range(0, 4 * SIZE - 1) & 32'hFFFFFFFC;
        bus.req_wdata  = $urandom;
      end
    end
    bus.req_valid = 1'b0;
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_rdata"}, rdata, exp_rd);
    if (exp_err) check({tag, "_no_write"}, 32'(we_seen), 32'd0);
    if (idx < SIZE) check({tag, "_mem"}, mem[idx[5:0]], ref_mem[idx[5:0]]);
  endtask

  logic [31:0] r;
  logic [31:0] last_addr;
  logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_resp_err", 32'(bus.resp_err), 32'd0);
    check("reset_rdata", bus.resp_rdata, 32'h0);
    check("reset_we", 32'(bus.mem_write_enable), 32'd0);
    check("reset_wdata", bus.mem_write_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < SIZE; i++) preload(i, $urandom);

    preload(0, 32'h8899AABB);
    do_req(1'b0, 3'd0, 32'h1, 32'h0, "lb_1", r);   check("lb_1_const", r, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h3, 32'h0, "lbu_3", r);  check("lbu_3_const", r, 32'h00000088);
    do_req(1'b0, 3'd5, 32'h2, 32'h0, "lhu_2", r);  check("lhu_2_const", r, 32'h00008899);
    do_req(1'b0, 3'd1, 32'h0, 32'h0, "lh_0", r);   check("lh_0_const", r, 32'hFFFFAABB);
    do_req(1'b1, 3'd0, 32'h2, 32'h1234565A, "sb_2", r);
    check("sb_2_word", mem[0], 32'h885AAABB);
    do_req(1'b0, 3'd2, 32'h0, 32'h0, "lw_0", r);   check("lw_0_const", r, 32'h885AAABB);
    do_req(1'b1, 3'd1, 32'h5, 32'hCAFE, "sh_5_err", r);
    do_req(1'b0, 3'd2, 4 * SIZE, 32'h0, "lw_oor", r);
    do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, "sw_8", r);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, "lw_8", r);   check("lw_8_const", r, 32'hDEADBEEF);

    // Reset during RMW_WRITE must drop the pending write.
    preload(3, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'hC; bus.req_wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rmw_rst_we", 32'(bus.mem_write_enable), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rmw_rst_busy", 32'(bus.busy), 32'd0);
    check("rmw_rst_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    check("rmw_rst_word", mem[3], 32'h11223344);

    last_addr = 32'h0;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [2:0]  f;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 4 * SIZE + $urandom_range(0, 1023);
      else if (sel < 3)  a = last_addr;
      else               a = $urandom_range(0, 4 * SIZE - 1);
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      else                           f = legal_f3[$urandom_range(0, 4)];
      do_req(1'($urandom_range(0, 1)), f, a, $urandom, $sformatf("rnd%0d", t), r);
      last_addr = a;
    end

    for (int i = 0; i < SIZE; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-organised, synchronous-read data memory. The memory has one address port, writes when write_enable is high and reads otherwise, with read data registered one cycle later.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory transactions.
- Sub-word stores are done by read-modify-write. Loads are extracted and sign- or zero-extended.
- Sits between the core's execute/memory stage and the data memory. Stalls the core through busy.

Parameters:
- N, 32, data/address width (byte address on the CPU side, word index on the memory side).
- SIZE, 64, memory depth in words; word indices >= SIZE are rejected.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; sampled only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  N  byte address.
- req_wdata  in  N  store data; low byte/half used for SB/SH.
- busy  out  1  high when not in IDLE; the core must hold its request while busy.
- resp_valid  out  1  one-cycle pulse: transaction complete.
- resp_rdata  out  N  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or out-of-range.
- mem_addr  out  N  word index, equal to req_addr >> 2 (latched copy after IDLE).
- mem_write_enable  out  1  memory write strobe.
- mem_write_data  out  N  memory write data.
- mem_read_data  in  N  memory read data, valid one cycle after the address is presented with write_enable low.

Behaviour:
- States: IDLE, LOAD_RESP, RMW_WRITE, DONE.
- Reset (rst high at an edge):
  - state becomes IDLE; busy, resp_valid and resp_err are 0; resp_rdata, mem_write_data and the latched addr/offset/funct3/data are 0.
  - mem_write_enable is forced 0 combinationally whenever rst is high.
  - Reset in any state abandons the transaction; a pending RMW write is never issued.
- IDLE, in the accept cycle (req_valid high):
  - mem_addr is driven combinationally from req_addr[N-1:2].
  - Latch word index, byte offset req_addr[1:0], funct3, req_write and req_wdata.
- Error check in the accept cycle:
  - H/HU/SH with addr[0] = 1 is an error.
  - W/SW with addr[1:0] != 0 is an error.
  - funct3 in {011, 110, 111} is an error; for stores, funct3[2] = 1 is also an error.
  - word index >= SIZE is an error.
  - On error: mem_write_enable stays 0, go to DONE with resp_err = 1.
- LW/LH/LB/LHU/LBU: mem_write_enable = 0 (read) and go to LOAD_RESP.
  - LOAD_RESP: resp_valid = 1. resp_rdata is extracted from mem_read_data at byte offset.
  - B uses bits [8*off+7 : 8*off]; H uses bits [16*off[1]+15 : 16*off[1]].
  - B/H are sign-extended; BU/HU and W are zero-extended.
  - Then return to IDLE. Load latency is 1 cycle after accept.
- SW: mem_write_enable = 1 and mem_write_data = req_wdata in the accept cycle; go to DONE.
- SB/SH: read the word (write_enable 0) in the accept cycle and go to RMW_WRITE.
  - RMW_WRITE: mem_addr is the latched index, mem_write_enable = 1.
  - mem_write_data = mem_read_data with the addressed lane replaced by the latched wdata[7:0] or wdata[15:0]; go to DONE.
- DONE: resp_valid = 1, resp_rdata = 0, resp_err = latched error; return to IDLE.
- Completion latency after accept: SW 1 cycle, SB/SH 2 cycles, errors 1 cycle.
- busy = (state != IDLE). req_valid while busy is ignored and never queued.
- Back-to-back requests: a new request can be accepted in the cycle after resp_valid.
  - A load issued right after a store to the same word returns the new data, because the write commits before the read edge.
- Outside IDLE, mem_addr holds the latched index. In IDLE with no request it is don't-care, and mem_write_enable is 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - typedef enum logic[1:0] lsu_state_t {IDLE, LOAD_RESP, RMW_WRITE, DONE};
  - helper function is_misaligned(funct3, offset).
- One combinational sub-module, lsu_lane_align, does load extract/extend and store lane merge (inputs: word, offset, funct3, wdata).
- The FSM and latches stay in load_store_unit.

Test Plan:
- Preload word 0 = 0x8899AABB. LB at addr 0x1 -> resp_rdata 0xFFFFFFAA one cycle after accept, resp_err 0.
- Preload word 0 = 0x8899AABB. LBU at 0x3 -> 0x00000088. LHU at 0x2 -> 0x00008899. LH at 0x0 -> 0xFFFFAABB.
- Preload word 0 = 0x8899AABB. SB wdata 0x1234565A at addr 0x2 -> busy for 2 cycles, memory word 0 = 0x885AAABB. A following LW at 0x0 returns 0x885AAABB.
- SH at 0x5 -> resp_err 1 after 1 cycle, mem_write_enable never high, word 1 unchanged. LW at 4*SIZE -> resp_err 1.
- SW 0xDEADBEEF at 0x8, then LW at 0x8 on the very next accept -> 0xDEADBEEF.
- SB issued, then rst asserted during RMW_WRITE -> mem_write_enable 0, word unchanged, state IDLE, busy 0 next cycle.
